// File: rtl/fifo_rr_scheduler_if.sv
// Handshake bundle between fifo_rr_scheduler, its producers, the shared fifo
// and the downstream consumer.
interface fifo_rr_scheduler_if #(
  parameter int N_REQ       = 4,
  parameter int FIFO_WIDTH  = 2,
  parameter int N_ADDR_BITS = 2
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*FIFO_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic                        fifo_wr_en;
  logic [FIFO_WIDTH-1:0]       fifo_wr_data;
  logic                        fifo_rd_en;
  logic [FIFO_WIDTH-1:0]       fifo_rd_data;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        out_valid;
  logic [FIFO_WIDTH-1:0]       out_data;
  logic                        out_ready;
  logic [N_ADDR_BITS:0]        occupancy;

  modport master (
    input  req_valid, req_data, fifo_rd_data, fifo_full, fifo_empty, out_ready,
    output req_ready, fifo_wr_en, fifo_wr_data, fifo_rd_en, out_valid, out_data, occupancy
  );

  modport slave (
    output req_valid, req_data, fifo_rd_data, fifo_full, fifo_empty, out_ready,
    input  req_ready, fifo_wr_en, fifo_wr_data, fifo_rd_en, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/fifo_rr_scheduler.sv
// Round-robin producer arbitration into one shared fifo, draining into a
// registered ready/valid stage; write and read slots never share a cycle.
module fifo_rr_scheduler #(
  parameter int N_REQ       = 4,
  parameter int FIFO_WIDTH  = 2,
  parameter int N_ADDR_BITS = 2
) (
  input logic                 clk,
  input logic                 reset,
  fifo_rr_scheduler_if.master bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int OW = N_ADDR_BITS + 1;

  typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_e;

  op_e                              last_op;
  logic [PW-1:0]                    rr_ptr;
  logic [PW-1:0]                    gnt_idx;
  logic [PW-1:0]                    idx;
  logic                             found;
  logic                             wr_pend, rd_pend, do_wr, do_rd;
  logic [N_REQ-1:0][FIFO_WIDTH-1:0] req_data_a;
  logic                             out_valid_q;
  logic [FIFO_WIDTH-1:0]            out_data_q;
  logic [OW-1:0]                    occ_q;

  assign req_data_a = bus.req_data;

  // With both sides pending the slot alternates, so neither side starves.
  always_comb begin
    wr_pend = (|bus.req_valid) && !bus.fifo_full;
    rd_pend = !bus.fifo_empty && (!out_valid_q || bus.out_ready);
    do_wr   = wr_pend && (!rd_pend || (last_op == OP_READ));
    do_rd   = rd_pend && (!wr_pend || (last_op == OP_WRITE));
  end

  // First requester after the last winner, wrapping.
  always_comb begin
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && bus.req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign bus.req_ready[i] = do_wr && (gnt_idx == PW'(i));
  end

  assign bus.fifo_wr_en   = do_wr;
  assign bus.fifo_wr_data = do_wr ? req_data_a[gnt_idx] : '0;
  assign bus.fifo_rd_en   = do_rd;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.occupancy    = occ_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      occ_q       <= '0;
      rr_ptr      <= PW'(N_REQ - 1);
      last_op     <= OP_READ;
    end else begin
      if (do_wr) begin
        rr_ptr  <= gnt_idx;
        last_op <= OP_WRITE;
        occ_q   <= occ_q + OW'(1);
      end else if (do_rd) begin
        last_op <= OP_READ;
        occ_q   <= occ_q - OW'(1);
      end
      // A read slot refills the stage even while it is being consumed.
      if (do_rd) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.fifo_rd_data;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule
